jenc_stream_sequencer: RTL
==========================

// Module: jenc_stream_sequencer
// PURPOSE
//  Frame-level sequencer between the JFIF header source and the entropy-coded stream from the bit packer.
//  On start it passes the header stream, then the entropy stream, then appends the EOI marker (FFD9).
//  It drives a single 32-bit byte-lane output towards the byte-stuffing/FIFO stage.
//  Reports busy, frame completion, and an abort/error indication to the camera control block.
// PARAMETERS
//  DW     32  data width; byte lanes are MSB-first, so byte 0 is on [DW-1:DW-8]
//  NB_W    3  width of the nbytes fields (values 1..4)
//  CNT_W  24  width of the frame byte counter (only with JENC_SEQ_BYTE_COUNT_EN)
// PORTS
//  clk          in   1      clock
//  resetn       in   1      synchronous reset, active low
//  start        in   1      single-cycle pulse; begins a frame when in IDLE
//  abort        in   1      single-cycle pulse; abandons the current frame
//  hdr_data     in   DW     header bytes, MSB-first
//  hdr_nbytes   in   NB_W   number of valid bytes in hdr_data (1..4)
//  hdr_tlast    in   1      last header beat
//  hdr_valid    in   1      header beat valid
//  hdr_hold     out  1      backpressure to the header source
//  ecs_data     in   DW     entropy-coded bytes from the bit packer
//  ecs_nbytes   in   NB_W   number of valid bytes in ecs_data (1..4)
//  ecs_tlast    in   1      last entropy beat of the frame
//  ecs_valid    in   1      entropy beat valid
//  ecs_hold     out  1      backpressure to the bit packer
//  out_data     out  DW     output bytes, MSB-first
//  out_nbytes   out  NB_W   number of valid bytes in out_data
//  out_tlast    out  1      last beat of the frame (the EOI beat)
//  out_valid    out  1      output beat valid
//  out_hold     in   1      backpressure from downstream
//  busy         out  1      high whenever state is not IDLE
//  frame_done   out  1      one-cycle pulse when a frame ends
//  frame_err    out  1      qualifies frame_done: 1 means the frame was aborted
// BEHAVIOUR
//  Handshake: a beat transfers when valid & ~hold; the producer holds data stable while valid & hold.
//  Reset: state=IDLE; out_valid, out_tlast, busy, frame_done, frame_err = 0; out_data and out_nbytes undefined.
//  FSM:
//   IDLE  -> HDR   on start
//   HDR   -> ECS   when the hdr_tlast beat is accepted
//   ECS   -> EOI   when the ecs_tlast beat is accepted
//   EOI   -> IDLE  when the EOI beat is accepted downstream; frame_done=1, frame_err=0
//  Output is a single registered stage; latency is 1 cycle from input acceptance to out_valid.
//  The register loads whenever ~(out_valid & out_hold).
//  Routing:
//   HDR: hdr_hold = out_valid & out_hold; ecs_hold = 1.
//   ECS: the same rule with the two sources swapped.
//   All other states: both holds = 1, except DRAIN.
//  Each input beat is forwarded unchanged (data, nbytes); out_tlast=0 for header and entropy beats.
//  EOI beat: out_data = {16'hFFD9, 16'h0}, out_nbytes = 2, out_tlast = 1.
//   It is loaded in the cycle after the ecs_tlast beat is accepted, subject to the same hold rule.
//  start outside IDLE is ignored; start and abort together in IDLE: start wins.
//  abort in HDR or ECS -> DRAIN. A beat offered in the same cycle is not accepted.
//  DRAIN:
//   The current source is sunk (hold=0, nothing forwarded) until its tlast beat.
//   The other source stays held.
//   An already-registered output beat is still delivered.
//   If aborted in HDR, DRAIN sinks the header, then the entire entropy frame.
//   When done -> IDLE with frame_done=1 and frame_err=1.
//  abort in EOI, IDLE or DRAIN is ignored.
//  Resetting mid-frame drops the output beat in the register; input sources must be reset alongside.
// CONFIGURATION
//  JENC_SEQ_BYTE_COUNT_EN defined:
//   Adds output frame_bytes [CNT_W-1:0], the running sum of out_nbytes accepted downstream.
//   The count includes EOI, is cleared on start, holds after frame_done, and saturates at all-ones.
//  Not defined: the port and the counter are absent.
// STRUCTURE
//  Package jenc_seq_pkg holds:
//   state enum {IDLE, HDR, ECS, EOI, DRAIN};
//   JENC_EOI_WORD = 32'hFFD9_0000 and JENC_EOI_NBYTES = 3'd2.
//  Sub-module jenc_seq_oreg: the 1-deep output register with hold logic; the FSM and muxing stay in the top module.
// TESTING
//  Full frame:
//   Stimulus: 3 header beats (4,4,2 bytes), then 2 entropy beats (4,3 bytes), out_hold=0.
//   Response: 6 output beats, the last being FFD9_0000 with nbytes=2 and tlast=1; one frame_done pulse with err=0.
//  Backpressure:
//   Stimulus: out_hold toggled every cycle across a full frame.
//   Response: no beat lost or duplicated; hdr_hold/ecs_hold mirror out_valid&out_hold.
//  Abort in ECS:
//   Stimulus: abort after entropy beat 1 of 5.
//   Response: beats 2..5 are sunk with no output; frame_done=1, frame_err=1; no EOI beat.
//  Abort in HDR:
//   Stimulus: abort during the header.
//   Response: the remaining header and the whole entropy frame are drained, then IDLE with err=1.
//  Start while busy:
//   Stimulus: start pulsed during ECS.
//   Response: ignored; the frame completes normally and the next start is accepted.
//  With JENC_SEQ_BYTE_COUNT_EN:
//   Stimulus: the full-frame case.
//   Response: frame_bytes = 10 + 7 + 2 = 19.

Source files
------------

// File: rtl/jenc_seq_pkg.sv
// Shared types and constants for the JPEG frame stream sequencer.
package jenc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ECS,
    EOI,
    DRAIN
  } seq_state_t;

  localparam logic [31:0] JENC_EOI_WORD   = 32'hFFD9_0000;
  localparam logic [2:0]  JENC_EOI_NBYTES = 3'd2;

endpackage

// File: rtl/jenc_seq_oreg.sv
// One-deep registered output stage; loads whenever the held beat is not stalled downstream.
module jenc_seq_oreg #(
  parameter int DW   = 32,
  parameter int NB_W = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic [NB_W-1:0] in_nbytes,
  input  logic            in_tlast,
  output logic            ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [NB_W-1:0] out_nbytes,
  output logic            out_tlast,
  input  logic            out_hold
);

  assign ready = ~(out_valid & out_hold);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_tlast <= 1'b0;
    end else if (ready) begin
      out_valid <= in_valid;
      out_tlast <= in_valid & in_tlast;
    end
  end

  // Payload needs no reset; it is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (ready) begin
      out_data   <= in_data;
      out_nbytes <= in_nbytes;
    end
  end

endmodule

// File: rtl/jenc_stream_sequencer.sv
// Frame sequencer: header stream, then entropy stream, then EOI marker, onto one byte-lane output.
// Optional build macro JENC_SEQ_BYTE_COUNT_EN adds the frame_bytes delivered-byte counter.
//
// state | meaning
// IDLE  | waiting for start
// HDR   | forwarding header beats
// ECS   | forwarding entropy-coded beats
// EOI   | emitting the FFD9 beat and waiting for it to leave
// DRAIN | aborted: sinking the rest of the current frame's inputs
module jenc_stream_sequencer
  import jenc_seq_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NB_W = 3
`ifdef JENC_SEQ_BYTE_COUNT_EN
  , parameter int CNT_W = 24
`endif
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            abort,
  input  logic [DW-1:0]   hdr_data,
  input  logic [NB_W-1:0] hdr_nbytes,
  input  logic            hdr_tlast,
  input  logic            hdr_valid,
  output logic            hdr_hold,
  input  logic [DW-1:0]   ecs_data,
  input  logic [NB_W-1:0] ecs_nbytes,
  input  logic            ecs_tlast,
  input  logic            ecs_valid,
  output logic            ecs_hold,
  output logic [DW-1:0]   out_data,
  output logic [NB_W-1:0] out_nbytes,
  output logic            out_tlast,
  output logic            out_valid,
  input  logic            out_hold,
  output logic            busy,
  output logic            frame_done,
  output logic            frame_err
`ifdef JENC_SEQ_BYTE_COUNT_EN
  , output logic [CNT_W-1:0] frame_bytes
`endif
);

  localparam logic [DW-1:0]   EOI_DATA = DW'(JENC_EOI_WORD) << (DW - 32);
  localparam logic [NB_W-1:0] EOI_NB   = NB_W'(JENC_EOI_NBYTES);

  seq_state_t state, state_nxt;
  logic drain_hdr, drain_hdr_nxt;
  logic eoi_sent, eoi_sent_nxt;
  logic done_nxt, err_nxt;
  logic ready;
  logic            ld_valid;
  logic [DW-1:0]   ld_data;
  logic [NB_W-1:0] ld_nbytes;
  logic            ld_tlast;

  always_comb begin
    state_nxt     = state;
    drain_hdr_nxt = drain_hdr;
    eoi_sent_nxt  = eoi_sent;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    hdr_hold      = 1'b1;
    ecs_hold      = 1'b1;
    ld_valid      = 1'b0;
    ld_data       = hdr_data;
    ld_nbytes     = hdr_nbytes;
    ld_tlast      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = HDR;
          eoi_sent_nxt = 1'b0;
        end
      end
      HDR: begin
        if (abort) begin
          state_nxt     = DRAIN;
          drain_hdr_nxt = 1'b1;
        end else begin
          hdr_hold = ~ready;
          ld_valid = hdr_valid & ready;
          if (ld_valid && hdr_tlast) state_nxt = ECS;
        end
      end
      ECS: begin
        ld_data   = ecs_data;
        ld_nbytes = ecs_nbytes;
        if (abort) begin
          state_nxt     = DRAIN;
          drain_hdr_nxt = 1'b0;
        end else begin
          ecs_hold = ~ready;
          ld_valid = ecs_valid & ready;
          if (ld_valid && ecs_tlast) state_nxt = EOI;
        end
      end
      EOI: begin
        if (!eoi_sent && ready) begin
          ld_valid     = 1'b1;
          ld_data      = EOI_DATA;
          ld_nbytes    = EOI_NB;
          ld_tlast     = 1'b1;
          eoi_sent_nxt = 1'b1;
        end
        if (eoi_sent && out_valid && out_tlast && !out_hold) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      DRAIN: begin
        // Header drain rolls over into draining the whole entropy frame.
        if (drain_hdr) begin
          hdr_hold = 1'b0;
          if (hdr_valid && hdr_tlast) drain_hdr_nxt = 1'b0;
        end else begin
          ecs_hold = 1'b0;
          if (ecs_valid && ecs_tlast) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      drain_hdr  <= 1'b0;
      eoi_sent   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_hdr  <= drain_hdr_nxt;
      eoi_sent   <= eoi_sent_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
    end
  end

  assign busy = (state != IDLE);

  jenc_seq_oreg #(
    .DW   (DW),
    .NB_W (NB_W)
  ) u_oreg (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (ld_valid),
    .in_data    (ld_data),
    .in_nbytes  (ld_nbytes),
    .in_tlast   (ld_tlast),
    .ready      (ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .out_tlast  (out_tlast),
    .out_hold   (out_hold)
  );

`ifdef JENC_SEQ_BYTE_COUNT_EN
  logic [CNT_W:0] byte_sum;

  assign byte_sum = {1'b0, frame_bytes} + (CNT_W + 1)'(out_nbytes);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_bytes <= '0;
    end else if (state == IDLE && start) begin
      frame_bytes <= '0;
    end else if (out_valid && !out_hold) begin
      frame_bytes <= byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
    end
  end
`else
  // Without the counter nothing tallies delivered bytes.
`endif

endmodule
